relin_key_tile_streamer: RTL and testbench

- Streams relinearisation-key tiles from an external synchronous key SRAM into the polynomial multiplier over a valid/ready interface.
- Generalises the earlier loader in four ways:
  - N key components instead of a fixed c0/c1 pair.
  - Fixed-latency memory reads instead of a wide flat register-file port.
  - Multi-pass repeat.
  - Credit-based backpressure through an internal FIFO, plus flush.
- Sits between the key SRAM and the multiplier's key input stage.

---
 rtl/relin_key_tile_streamer_if.sv | 36 +++
 rtl/relin_key_tile_streamer.sv | 173 +++++++++++++++++
 tb/tb_relin_key_tile_streamer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/relin_key_tile_streamer_if.sv
// rtl/relin_key_tile_streamer_if.sv - key SRAM read port and key tile stream bundle
interface relin_key_tile_streamer_if #(
  parameter int TILE_WIDTH     = 8,
  parameter int KEY_LENGTH     = 512,
  parameter int NUM_KEYS       = 8,
  parameter int NUM_COMPONENTS = 2,
  parameter int DATA_WIDTH     = 64
);
  localparam int TILES   = KEY_LENGTH / TILE_WIDTH;
  localparam int TDATA_W = NUM_KEYS * TILE_WIDTH * DATA_WIDTH;
  localparam int ADDR_W  = $clog2(NUM_COMPONENTS * TILES);
  localparam int TIDX_W  = $clog2(TILES);

  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [TDATA_W-1:0] mem_rd_data;
  logic               tile_valid;
  logic               tile_ready;
  logic [TDATA_W-1:0] tile_data;
  logic [TIDX_W-1:0]  tile_index;
  logic               tile_last;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output tile_valid, tile_data, tile_index, tile_last,
    input  tile_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  tile_valid, tile_data, tile_index, tile_last,
    output tile_ready
  );
endinterface

// File: rtl/relin_key_tile_streamer.sv
// rtl/relin_key_tile_streamer.sv - streams relinearisation-key tiles from key SRAM to the multiplier
module relin_key_tile_streamer #(
  parameter int TILE_WIDTH     = 8,
  parameter int KEY_LENGTH     = 512,
  parameter int NUM_KEYS       = 8,
  parameter int NUM_COMPONENTS = 2,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_LATENCY    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(NUM_COMPONENTS)-1:0] component_sel,
  input  logic [7:0]                        num_passes,
  input  logic                              flush,
  output logic                              busy,
  output logic                              done,
  relin_key_tile_streamer_if.master         bus
);
  localparam int TILES   = KEY_LENGTH / TILE_WIDTH;
  localparam int TDATA_W = NUM_KEYS * TILE_WIDTH * DATA_WIDTH;
  localparam int ADDR_W  = $clog2(NUM_COMPONENTS * TILES);
  localparam int TIDX_W  = $clog2(TILES);
  localparam int COMP_W  = $clog2(NUM_COMPONENTS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_next;

  logic [COMP_W-1:0] comp_clamped;
  logic [ADDR_W-1:0] start_base, base_addr, addr;
  logic [7:0]        passes, pass_cnt;
  logic [TIDX_W-1:0] tile_idx;
  logic              last_issue, issue, start_ok;
  int                inflight;

  logic              pipe_valid [MEM_LATENCY];
  logic [TIDX_W-1:0] pipe_idx   [MEM_LATENCY];
  logic              pipe_last  [MEM_LATENCY];

  logic [TDATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [TIDX_W-1:0]  fifo_idx  [FIFO_DEPTH];
  logic               fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               push, pop, fifo_valid;

  assign comp_clamped = (int'(component_sel) >= NUM_COMPONENTS) ? COMP_W'(NUM_COMPONENTS - 1)
                                                                : component_sel;
  assign start_base = ADDR_W'(int'(comp_clamped) * TILES);
  assign last_issue = (tile_idx == TIDX_W'(TILES - 1)) && (pass_cnt == passes - 8'd1);

  assign fifo_valid = (fifo_count != '0);
  assign push       = pipe_valid[MEM_LATENCY-1];
  assign pop        = fifo_valid && bus.tile_ready;

  // Credits cover every read whose data has not yet left the FIFO, so a push always finds room.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < MEM_LATENCY; i++) inflight += int'(pipe_valid[i]);
    issue = (state == ISSUE) && !flush && (inflight + int'(fifo_count) < FIFO_DEPTH);
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      IDLE:    if (start) begin
                 state_next = ISSUE;
                 start_ok   = 1'b1;
               end
      ISSUE:   if (issue && last_issue) state_next = DRAIN;
      DRAIN:   if (pop && fifo_last[rd_ptr]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      start_ok   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      passes    <= 8'd1;
      pass_cnt  <= '0;
      tile_idx  <= '0;
      base_addr <= '0;
      addr      <= '0;
    end else begin
      state <= state_next;
      done  <= (state == DRAIN) && !flush && pop && fifo_last[rd_ptr];
      if (start_ok) begin
        passes    <= (num_passes == 8'd0) ? 8'd1 : num_passes;
        pass_cnt  <= '0;
        tile_idx  <= '0;
        base_addr <= start_base;
        addr      <= start_base;
      end else if (issue) begin
        if (tile_idx == TIDX_W'(TILES - 1)) begin
          tile_idx <= '0;
          pass_cnt <= pass_cnt + 8'd1;
          addr     <= base_addr;
        end else begin
          tile_idx <= tile_idx + 1'b1;
          addr     <= addr + 1'b1;
        end
      end
    end
  end

  // Tag pipeline mirrors the SRAM latency; flush kills the tags so late data is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_idx[i]   <= '0;
        pipe_last[i]  <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_idx[0]   <= tile_idx;
      pipe_last[0]  <= last_issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
      if (flush) begin
        for (int i = 0; i < MEM_LATENCY; i++) pipe_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_rd_data;
      fifo_idx[wr_ptr]  <= pipe_idx[MEM_LATENCY-1];
      fifo_last[wr_ptr] <= pipe_last[MEM_LATENCY-1];
    end
  end

  always @(posedge clk) begin
    if (reset && !flush && push && !pop) assert (int'(fifo_count) < FIFO_DEPTH);
  end

  assign busy           = (state != IDLE);
  assign bus.mem_rd_en  = issue;
  assign bus.mem_addr   = addr;
  assign bus.tile_valid = fifo_valid;
  assign bus.tile_data  = fifo_valid ? fifo_data[rd_ptr] : '0;
  assign bus.tile_index = fifo_valid ? fifo_idx[rd_ptr] : '0;
  assign bus.tile_last  = fifo_valid && fifo_last[rd_ptr];
endmodule

// File: tb/tb_relin_key_tile_streamer.sv
// tb/tb_relin_key_tile_streamer.sv - table-driven bench for relin_key_tile_streamer
module tb_relin_key_tile_streamer;
  localparam int TILES   = 64;
  localparam int TDATA_W = 4096;

  typedef struct {
    logic [0:0] comp;
    logic [7:0] passes;
    int         mode;
    int         exp_tiles;
    int         restart_cyc;
    int         flush_cyc;
  } job_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic [0:0] component_sel = 1'b0;
  logic [7:0] num_passes = 8'd0;
  logic       busy, done;
  int         n_cmp = 0;
  int         n_bad = 0;
  job_t       jobs[7];

  relin_key_tile_streamer_if bus ();

  relin_key_tile_streamer dut (
    .clk(clk), .reset(reset), .start(start), .component_sel(component_sel),
    .num_passes(num_passes), .flush(flush), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [TDATA_W-1:0] pat(input int a);
    logic [TDATA_W-1:0] r;
    for (int w = 0; w < 64; w++) r[w*64 +: 64] = {32'h5EED0000 + 32'(a), 32'(w)};
    return r;
  endfunction

  function automatic int words_diff(input logic [TDATA_W-1:0] a, input logic [TDATA_W-1:0] b);
    int n = 0;
    for (int w = 0; w < 64; w++) if (a[w*64 +: 64] !== b[w*64 +: 64]) n++;
    return n;
  endfunction

  // Key SRAM: two-cycle read latency
  logic [6:0] a1, a2;
  always @(posedge clk) begin
    a1 <= bus.mem_addr;
    a2 <= a1;
  end
  assign bus.mem_rd_data = pat(int'(a2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_job(input job_t j);
    int issued, popped, first_valid, done_cyc, e;
    bit stalled;
    logic [TDATA_W-1:0] held_data;
    logic [5:0] held_idx;
    logic held_last;
    issued = 0; popped = 0; first_valid = -1; done_cyc = -1; stalled = 0;
    held_data = '0; held_idx = '0; held_last = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == j.restart_cyc);
      if (cyc == 0) begin
        component_sel = j.comp;
        num_passes    = j.passes;
      end
      if (cyc == j.restart_cyc) begin
        component_sel = ~j.comp;
        num_passes    = 8'd5;
      end
      flush = (cyc == j.flush_cyc);
      case (j.mode)
        0:       bus.tile_ready = 1'b1;
        1:       bus.tile_ready = (cyc < 30) ? cyc[0] : ((cyc < 50) ? 1'b0 : 1'b1);
        default: bus.tile_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0) begin
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_tile_valid", 64'(bus.tile_valid), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        continue;
      end
      if (done) begin
        check("done_busy", 64'(busy), 64'd0);
        check("done_tile_count", 64'(popped), 64'(j.exp_tiles));
        done_cyc = cyc;
        break;
      end
      check("busy", 64'(busy), 64'd1);
      check("mem_rd_en", 64'(bus.mem_rd_en),
            64'(!flush && issued < j.exp_tiles && (issued - popped) < 4));
      if (bus.mem_rd_en) begin
        check("mem_addr", 64'(bus.mem_addr), 64'(int'(j.comp) * TILES + issued % TILES));
        issued++;
      end
      if (stalled) begin
        check("held_valid", 64'(bus.tile_valid), 64'd1);
        check("held_index", 64'(bus.tile_index), 64'(held_idx));
        check("held_last", 64'(bus.tile_last), 64'(held_last));
        check("held_data_words_changed", 64'(words_diff(bus.tile_data, held_data)), 64'd0);
      end
      if (bus.tile_valid && first_valid < 0) first_valid = cyc;
      if (bus.tile_valid && bus.tile_ready) begin
        e = popped % TILES;
        check("tile_index", 64'(bus.tile_index), 64'(e));
        check("tile_data_words_wrong",
              64'(words_diff(bus.tile_data, pat(int'(j.comp) * TILES + e))), 64'd0);
        check("tile_last", 64'(bus.tile_last), 64'(popped == j.exp_tiles - 1));
        popped++;
      end
      stalled   = bus.tile_valid && !bus.tile_ready;
      held_data = bus.tile_data;
      held_idx  = bus.tile_index;
      held_last = bus.tile_last;
      if (cyc == j.flush_cyc) break;
    end
    if (j.flush_cyc < 0) check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("first_valid_cycle", 64'(first_valid), 64'd4);
    if (j.mode == 0 && j.flush_cyc < 0)
      check("done_cycle", 64'(done_cyc), 64'(4 + j.exp_tiles));
  endtask

  initial begin
    jobs[0] = '{1'b1, 8'd1, 0, 64, -1, -1};
    jobs[1] = '{1'b0, 8'd3, 0, 192, -1, -1};
    jobs[2] = '{1'b1, 8'd0, 0, 64, 10, -1};
    jobs[3] = '{1'b0, 8'd1, 1, 64, -1, -1};
    jobs[4] = '{1'b1, 8'd2, 2, 128, -1, -1};
    jobs[5] = '{1'b0, 8'd1, 0, 64, -1, 13};
    jobs[6] = '{1'b1, 8'd1, 0, 64, -1, -1};
    bus.tile_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("reset_tile_valid", 64'(bus.tile_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) run_job(jobs[k]);

    // Asynchronous reset while draining the last tiles of a job
    @(negedge clk);
    start = 1'b1; component_sel = 1'b1; num_passes = 8'd1; flush = 1'b0;
    bus.tile_ready = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_reset_valid", 64'(bus.tile_valid), 64'd1);
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_rd_en", 64'(bus.mem_rd_en), 64'd0);
    #1 reset = 1'b0;
    #1;
    check("async_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("async_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("async_tile_valid", 64'(bus.tile_valid), 64'd0);
    check("async_tile_index", 64'(bus.tile_index), 64'd0);
    check("async_tile_last", 64'(bus.tile_last), 64'd0);
    check("async_tile_data_words", 64'(words_diff(bus.tile_data, '0)), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_valid", 64'(bus.tile_valid), 64'd0);
    end
    run_job(jobs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
